// File: rtl/i2s_frame_tx.sv
// i2s_frame_tx: serial row-frame transmitter for the i2s_mask LED module chain.
// Sends a 16-bit header {x,y,2'b00,row} and then (x+1)*(y+1) pixel words, MSB first.
// Optional macro I2S_TX_PARITY_EN appends one XOR parity bit over the row's data bits.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               begin one row (ignored while busy)
//   num_modules_x/y     array size minus 1, latched on accepted start
//   word_data/valid     upstream pixel word source
//   word_ready          word taken when word_valid & word_ready
//   i2s_data            serial data (registered)
//   i2s_clk_en          bit-clock enable (registered)
//   busy, row_num       row in progress, row index for the header
//   row_done            one-cycle pulse after the last bit of a row
module i2s_frame_tx #(
  parameter int NUM_ROWS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  num_modules_x,
  input  logic [3:0]  num_modules_y,
  input  logic [15:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        i2s_data,
  output logic        i2s_clk_en,
  output logic        busy,
  output logic [5:0]  row_num,
  output logic        row_done
);

  localparam logic [5:0] LAST_ROW = 6'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef I2S_TX_PARITY_EN
    S_STALL,
    S_PAR
`else
    S_STALL
`endif
  } state_t;

  state_t      r_st;
  state_t      w_nxt;
  logic [15:0] r_sh;
  logic [3:0]  r_cnt;
  logic [3:0]  r_nx;
  logic [3:0]  r_ny;
  logic [8:0]  r_taken;
  logic [5:0]  r_row;
  logic        r_en;
  logic        r_done;
`ifdef I2S_TX_PARITY_EN
  logic        r_par;
  logic        w_topar;
`endif

  logic        w_start;
  logic        w_load;
  logic        w_ready;
  logic        w_end;
  logic        w_en;
  logic        w_shift;
  logic [4:0]  w_x1;
  logic [4:0]  w_y1;
  logic [9:0]  w_tot;
  logic [9:0]  w_left;

  // Words still to be loaded this row, from the latched array size.
  assign w_x1   = {1'b0, r_nx} + 5'd1;
  assign w_y1   = {1'b0, r_ny} + 5'd1;
  assign w_tot  = {5'd0, w_x1} * {5'd0, w_y1};
  assign w_left = w_tot - {1'b0, r_taken};

  always_comb begin
    w_nxt   = r_st;
    w_start = 1'b0;
    w_load  = 1'b0;
    w_ready = 1'b0;
    w_end   = 1'b0;
`ifdef I2S_TX_PARITY_EN
    w_topar = 1'b0;
`endif
    unique case (r_st)
      S_IDLE: begin
        if (start) begin
          w_start = 1'b1;
          w_nxt   = S_HDR;
        end
      end
      S_HDR, S_DATA: begin
        if (r_cnt == 4'd0) begin
          if (w_left != 10'd0) begin
            w_ready = 1'b1;
            if (word_valid) begin
              w_load = 1'b1;
              w_nxt  = S_DATA;
            end else begin
              w_nxt  = S_STALL;
            end
          end else begin
`ifdef I2S_TX_PARITY_EN
            w_topar = 1'b1;
            w_nxt   = S_PAR;
`else
            w_end   = 1'b1;
            w_nxt   = S_IDLE;
`endif
          end
        end
      end
      S_STALL: begin
        w_ready = 1'b1;
        if (word_valid) begin
          w_load = 1'b1;
          w_nxt  = S_DATA;
        end
      end
`ifdef I2S_TX_PARITY_EN
      S_PAR: begin
        w_end = 1'b1;
        w_nxt = S_IDLE;
      end
`endif
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_en = (w_nxt == S_HDR) || (w_nxt == S_DATA)
`ifdef I2S_TX_PARITY_EN
             || (w_nxt == S_PAR)
`endif
             ;

  // Shift only mid-word; on the last bit the register holds so a stall
  // keeps i2s_data steady.
  assign w_shift = ((r_st == S_HDR) || (r_st == S_DATA)) && (r_cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) r_st <= S_IDLE;
    else     r_st <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_nx    <= '0;
      r_ny    <= '0;
      r_taken <= '0;
      r_row   <= '0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
`ifdef I2S_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_en   <= w_en;
      r_done <= w_end;
      if (w_end)
        r_row <= (r_row == LAST_ROW) ? 6'd0 : r_row + 6'd1;
`ifdef I2S_TX_PARITY_EN
      if (r_st == S_DATA)
        r_par <= r_par ^ r_sh[15];
      if (w_start)
        r_par <= 1'b0;
`endif
      if (w_start) begin
        r_nx    <= num_modules_x;
        r_ny    <= num_modules_y;
        r_taken <= '0;
        r_sh    <= {num_modules_x, num_modules_y, 2'b00, r_row};
        r_cnt   <= 4'd15;
      end else if (w_load) begin
        r_sh    <= word_data;
        r_cnt   <= 4'd15;
        r_taken <= r_taken + 9'd1;
`ifdef I2S_TX_PARITY_EN
      end else if (w_topar) begin
        r_sh    <= {r_par ^ r_sh[15], 15'd0};
`endif
      end else if (w_shift) begin
        r_sh    <= {r_sh[14:0], 1'b0};
        r_cnt   <= r_cnt - 4'd1;
      end
    end
  end

  assign word_ready = w_ready;
  assign i2s_data   = r_sh[15];
  assign i2s_clk_en = r_en;
  assign busy       = (r_st != S_IDLE);
  assign row_num    = r_row;
  assign row_done   = r_done;

endmodule
